// File: rtl/cpu_dump_ctrl.sv
// Run-and-dump controller: enables the core for RUN_CYCLES cycles after start,
// then streams the register file and/or a data-memory window over valid/ready.
module cpu_dump_ctrl #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int DMEM_WORDS = 32,
  parameter int RUN_CYCLES = 40,
  parameter int IDX_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       dump_sel_i,
  output logic             cpu_en_o,
  output logic [IDX_W-1:0] rf_raddr_o,
  input  logic [XLEN-1:0]  rf_rdata_i,
  output logic [IDX_W-1:0] dmem_raddr_o,
  input  logic [XLEN-1:0]  dmem_rdata_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_data_o,
  output logic             out_kind_o,
  output logic [IDX_W-1:0] out_index_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_DUMP_RF  = 3'd2,
    S_DUMP_MEM = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RUN_LAST = (RUN_CYCLES > 0) ? CNT_W'(RUN_CYCLES - 1)
                                                           : {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] RF_LAST  = IDX_W'(NREGS - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(DMEM_WORDS - 1);
  localparam bit               SKIP_RUN = (RUN_CYCLES == 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       sel_q, sel_d;

  // First stage after the run phase; DONE when nothing is selected.
  function automatic state_e first_dump(input logic [1:0] sel);
    if (sel[0]) begin
      return S_DUMP_RF;
    end else if (sel[1]) begin
      return S_DUMP_MEM;
    end else begin
      return S_DONE;
    end
  endfunction

  // State, run counter, dump index and latched selection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          sel_d   = dump_sel_i;
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          state_d = SKIP_RUN ? first_dump(dump_sel_i) : S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1'b1);
        if (cnt_q == RUN_LAST) begin
          state_d = first_dump(sel_q);
        end else begin
          state_d = S_RUN;
        end
      end
      S_DUMP_RF: begin
        if (out_ready_i) begin
          if (idx_q == RF_LAST) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = sel_q[1] ? S_DUMP_MEM : S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1'b1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_DUMP_MEM: begin
        if (out_ready_i) begin
          if (idx_q == MEM_LAST) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1'b1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; read data passes straight through
  // because the frozen core keeps it stable while a beat is stalled.
  always_comb begin
    cpu_en_o     = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    out_valid_o  = 1'b0;
    out_kind_o   = 1'b0;
    out_index_o  = {IDX_W{1'b0}};
    rf_raddr_o   = {IDX_W{1'b0}};
    dmem_raddr_o = {IDX_W{1'b0}};
    out_data_o   = {XLEN{1'b0}};
    case (state_q)
      S_RUN: begin
        cpu_en_o = 1'b1;
        busy_o   = 1'b1;
      end
      S_DUMP_RF: begin
        busy_o      = 1'b1;
        out_valid_o = 1'b1;
        out_index_o = idx_q;
        rf_raddr_o  = idx_q;
        out_data_o  = rf_rdata_i;
      end
      S_DUMP_MEM: begin
        busy_o       = 1'b1;
        out_valid_o  = 1'b1;
        out_kind_o   = 1'b1;
        out_index_o  = idx_q;
        dmem_raddr_o = idx_q;
        out_data_o   = dmem_rdata_i;
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        done_o = 1'b0;
      end
    endcase
  end

endmodule
